// File: rtl/uart_mod_counter.sv
// Modulo-N tick counter for UART framing: counts baud/bit ticks, flags the terminal count, wraps or stops.
// Optional sticky overrun/clamp error output is enabled by defining UART_MOD_COUNTER_ERR_EN.
module uart_mod_counter #(
    parameter int CNT_W   = 4,
    parameter int MOD_MAX = 12,
    parameter int MOD_DEF = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             one_shot,
    input  logic [CNT_W:0]   mod_sel,
    output logic [CNT_W-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             done,
`ifdef UART_MOD_COUNTER_ERR_EN
    output logic             busy,
    output logic             err
`else
    output logic             busy
`endif
);

    localparam logic [CNT_W:0] MOD_MIN_V = (CNT_W + 1)'(2);
    localparam logic [CNT_W:0] MOD_TOP_V = (CNT_W + 1)'(MOD_MAX);
    localparam logic [CNT_W:0] MOD_DEF_V = (CNT_W + 1)'(MOD_DEF);
    localparam logic [CNT_W:0] ONE_V     = (CNT_W + 1)'(1);
    localparam logic [CNT_W:0] TWO_V     = (CNT_W + 1)'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [CNT_W:0] mod_q;
    logic [CNT_W:0] sel_clamped;
    logic [CNT_W:0] count_ext;
    logic           at_last;
    logic           next_is_last;
    logic           wrap_pend;

    always_comb begin
        sel_clamped = mod_sel;
        if (mod_sel < MOD_MIN_V) begin
            sel_clamped = MOD_MIN_V;
        end else if (mod_sel > MOD_TOP_V) begin
            sel_clamped = MOD_TOP_V;
        end
    end

    assign count_ext    = {1'b0, count};
    assign at_last      = (count_ext == (mod_q - ONE_V));
    assign next_is_last = ((count_ext + TWO_V) == mod_q);

    // tc is precomputed for the next state so it stays a pure function of registered state;
    // wrap is delayed one extra cycle through wrap_pend so it fires after count is back at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            mod_q     <= MOD_DEF_V;
            tc        <= 1'b0;
            wrap      <= 1'b0;
            wrap_pend <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wrap_pend <= 1'b0;
            wrap      <= wrap_pend;
            if (clr) begin
                state <= IDLE;
                count <= '0;
                mod_q <= sel_clamped;
                tc    <= 1'b0;
                wrap  <= 1'b0;
                done  <= 1'b0;
                busy  <= 1'b0;
            end else if (inc) begin
                case (state)
                    IDLE: begin
                        state <= RUN;
                        count <= CNT_W'(1);
                        mod_q <= sel_clamped;
                        busy  <= 1'b1;
                        tc    <= (sel_clamped == MOD_MIN_V);
                    end
                    RUN: begin
                        if (at_last) begin
                            if (one_shot) begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                tc    <= 1'b1;
                            end else begin
                                count     <= '0;
                                tc        <= 1'b0;
                                wrap_pend <= 1'b1;
                            end
                        end else begin
                            count <= count + CNT_W'(1);
                            tc    <= next_is_last;
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= IDLE;
                        count <= '0;
                        tc    <= 1'b0;
                        done  <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef UART_MOD_COUNTER_ERR_EN
    logic sel_bad;

    assign sel_bad = (mod_sel < MOD_MIN_V) || (mod_sel > MOD_TOP_V);

    // A clr re-arms the flag from the modulus it carries; otherwise the flag only ever sets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (clr) begin
            err <= sel_bad;
        end else if (inc && (state == DONE)) begin
            err <= 1'b1;
        end else if (inc && (state == IDLE) && sel_bad) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_mod_counter.sv
// Self-checking bench for uart_mod_counter: vector table through a scoreboard queue, plus an async reset sequence.
module tb_uart_mod_counter;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             inc;
    logic             one_shot;
    logic [CNT_W:0]   mod_sel;
    logic [CNT_W-1:0] count;
    logic             tc;
    logic             wrap;
    logic             done;
    logic             busy;
`ifdef UART_MOD_COUNTER_ERR_EN
    logic             err;
`endif

    uart_mod_counter #(.CNT_W(CNT_W), .MOD_MAX(12), .MOD_DEF(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .inc      (inc),
        .one_shot (one_shot),
        .mod_sel  (mod_sel),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap),
        .done     (done),
`ifdef UART_MOD_COUNTER_ERR_EN
        .busy     (busy),
        .err      (err)
`else
        .busy     (busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       inc;
        logic       os;
        logic [4:0] ms;
        logic [3:0] cnt;
        logic       tc;
        logic       wrap;
        logic       done;
        logic       busy;
        logic       err;
    } vec_t;

    typedef struct {
        logic [3:0] cnt;
        logic       tc;
        logic       wrap;
        logic       done;
        logic       busy;
        logic       err;
        string      tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    function automatic void add(input logic c, input logic i, input logic os, input logic [4:0] ms,
                                input logic [3:0] cnt, input logic t, input logic w, input logic d,
                                input logic b, input logic e);
        vec_t v;
        v.clr = c; v.inc = i; v.os = os; v.ms = ms;
        v.cnt = cnt; v.tc = t; v.wrap = w; v.done = d; v.busy = b; v.err = e;
        vecs.push_back(v);
    endfunction

    task automatic checkField(input string tag, input string name, input logic [3:0] act, input logic [3:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s.%s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    task automatic pushExpect(input logic [3:0] cnt, input logic t, input logic w, input logic d,
                              input logic b, input logic e, input string tag);
        exp_t x;
        x.cnt = cnt; x.tc = t; x.wrap = w; x.done = d; x.busy = b; x.err = e; x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic checkOutput();
        exp_t x;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        x = sb.pop_front();
        checkField(x.tag, "count", count, x.cnt);
        checkField(x.tag, "tc",    {3'b0, tc},   {3'b0, x.tc});
        checkField(x.tag, "wrap",  {3'b0, wrap}, {3'b0, x.wrap});
        checkField(x.tag, "done",  {3'b0, done}, {3'b0, x.done});
        checkField(x.tag, "busy",  {3'b0, busy}, {3'b0, x.busy});
`ifdef UART_MOD_COUNTER_ERR_EN
        checkField(x.tag, "err",   {3'b0, err},  {3'b0, x.err});
`endif
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        clr      = v.clr;
        inc      = v.inc;
        one_shot = v.os;
        mod_sel  = v.ms;
        pushExpect(v.cnt, v.tc, v.wrap, v.done, v.busy, v.err, tag);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic runVectors(input string prefix);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("%s%0d", prefix, i));
        end
        vecs.delete();
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; inc = 1'b0; one_shot = 1'b0; mod_sel = 5'd10;
        repeat (2) @(posedge clk);
        #1;
        pushExpect(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
        checkOutput();
        rst = 1'b0;

        // Free-running mod 10 straight out of reset
        for (int c = 1; c <= 9; c++) add(0, 1, 0, 10, 4'(c), c == 9, 0, 0, 1, 0);
        add(0, 1, 0, 10, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 10, 0, 0, 1, 0, 1, 0);
        add(0, 0, 0, 10, 0, 0, 0, 0, 1, 0);

        // One-shot mod 7 with two overrun pulses
        add(1, 0, 1, 7, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 6; c++) add(0, 1, 1, 7, 4'(c), c == 6, 0, 0, 1, 0);
        for (int k = 7; k <= 9; k++) add(0, 1, 1, 7, 6, 1, 0, 1, 0, k > 7);

        // Clamp low: mod_sel 0 behaves as mod 2
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 1, 1, 0, 0, 1, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        add(0, 1, 0, 0, 1, 1, 0, 0, 1, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 1, 0, 1, 1);

        // Clamp high: mod_sel 15 behaves as mod 12
        add(1, 0, 0, 15, 0, 0, 0, 0, 0, 1);
        for (int c = 1; c <= 11; c++) add(0, 1, 0, 15, 4'(c), c == 11, 0, 0, 1, 1);
        add(0, 1, 0, 15, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 15, 0, 0, 1, 0, 1, 1);

        // clr together with inc at count 5
        add(1, 0, 0, 10, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 5; c++) add(0, 1, 0, 10, 4'(c), 0, 0, 0, 1, 0);
        add(1, 1, 0, 10, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 10, 0, 0, 0, 0, 0, 0);

        // mod_sel change mid-run is ignored
        add(1, 0, 0, 10, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 3; c++) add(0, 1, 0, 10, 4'(c), 0, 0, 0, 1, 0);
        for (int c = 4; c <= 9; c++) add(0, 1, 0, 8, 4'(c), c == 9, 0, 0, 1, 0);
        add(0, 1, 0, 8, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 8, 0, 0, 1, 0, 1, 0);

        // One-shot mod 2, then clr out of DONE
        add(1, 0, 1, 2, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 2, 1, 1, 0, 0, 1, 0);
        add(0, 1, 1, 2, 1, 1, 0, 1, 0, 0);
        add(1, 0, 0, 10, 0, 0, 0, 0, 0, 0);

        // Lead-in to the async reset at count 4
        add(1, 0, 0, 10, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 4; c++) add(0, 1, 0, 10, 4'(c), 0, 0, 0, 1, 0);

        runVectors("vec");

        inc = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        pushExpect(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "async_rst");
        checkOutput();
        @(posedge clk);
        #1;
        pushExpect(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_held");
        checkOutput();
        rst = 1'b0;

        for (int c = 1; c <= 9; c++) add(0, 1, 0, 10, 4'(c), c == 9, 0, 0, 1, 0);
        add(0, 1, 0, 10, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 10, 0, 0, 1, 0, 1, 0);
        runVectors("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_mod_counter.md
Name: uart_mod_counter

Overview:
- Parametrised modulo-N event counter for UART framing: counts bit or baud ticks and flags the terminal count.
- Generalises the fixed mod-10 frame counter to a runtime-selectable modulus (5..12 for data, parity and stop framing) with free-running or one-shot mode.
- Driven by a true system clock with a tick enable, not by a data-derived edge.
- Sits between the baud tick generator and the transmit FSM; the FSM uses tc/done to end a frame.

Parameters:
- CNT_W, 4, width of count output; must satisfy 2**CNT_W >= MOD_MAX.
- MOD_MAX, 12, largest accepted modulus; larger mod_sel values are clamped to this.
- MOD_DEF, 10, modulus loaded at reset; must lie in 2..MOD_MAX.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous active-high reset.
- clr  in  1  synchronous clear to IDLE; also samples mod_sel.
- inc  in  1  count enable, one clk-cycle pulse per event.
- one_shot  in  1  1 = stop at terminal count; 0 = free-running wrap.
- mod_sel  in  CNT_W+1  requested modulus N.
- count  out  CNT_W  current count value.
- tc  out  1  high while count == N-1 (Moore decode of registered state).
- wrap  out  1  one-cycle pulse after a free-running wrap to 0.
- done  out  1  one-shot completion flag, held until clr.
- busy  out  1  high in RUN state.

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, mod_q=MOD_DEF, tc=0, wrap=0, done=0, busy=0.
- Modulus handling:
  - mod_q is loaded from mod_sel on clr=1, and on inc=1 while in IDLE.
  - Clamp rule: mod_sel < 2 loads 2; mod_sel > MOD_MAX loads MOD_MAX.
  - mod_sel changes during RUN or DONE are ignored until the next load.
- States:
  - IDLE: count=0. inc moves to RUN with count=1, using the freshly loaded mod_q.
  - RUN: each inc increments count.
    - At count==mod_q-1 with inc and one_shot=0: count goes to 0, wrap pulses the next cycle, state stays RUN.
    - At count==mod_q-1 with inc and one_shot=1: state goes to DONE, count holds mod_q-1, done=1.
  - DONE: inc is ignored, count and done hold. clr goes to IDLE.
- tc = busy-or-done and (count == mod_q-1). tc is never combinationally dependent on inc. In IDLE tc=0.
- Special case mod_q=2: IDLE->RUN(count 1, tc=1) on the first inc; the next inc terminates.
- Priority: rst > clr > inc. clr together with inc: clear wins, the inc is dropped, mod_sel is sampled.
- one_shot is sampled at each terminal event, so it may change mid-frame.
- Latency: count, tc, busy and done update on the clk edge that samples inc. wrap asserts one cycle after the wrap edge for exactly one cycle.
- Any rst assertion mid-count returns all outputs to reset values immediately.

Optional Feature:
- Macro: UART_MOD_COUNTER_ERR_EN.
- With the macro defined:
  - Adds output err (1 bit, reset 0).
  - err sets sticky on inc while in DONE (event overrun), or on a clr/IDLE load with mod_sel outside 2..MOD_MAX.
  - err clears only on rst or clr, except that a clr carrying an out-of-range mod_sel sets err again.
- Without the macro: no err port. Overruns and clamps are silent; all other behaviour is identical.

Test Plan:
- Reset, then 10 inc pulses with one_shot=0 and mod_sel=10: count steps 1..9,0. tc is high only at count=9. wrap pulses once, one cycle after count returns to 0.
- clr with mod_sel=7, one_shot=1, then 9 inc pulses: done=1 after the 7th inc. count holds 6, tc=1, busy=0. inc pulses 8 and 9 change nothing (err=1 if UART_MOD_COUNTER_ERR_EN).
- mod_sel=0 then mod_sel=15 loaded via clr, each followed by free counting: the counter wraps at 2 and at 12 respectively. With UART_MOD_COUNTER_ERR_EN, err=1 after each out-of-range clr.
- clr and inc asserted together at count=5: count=0 next cycle, state IDLE, no wrap. Change mod_sel from 10 to 8 while at count=3 in RUN: the wrap still occurs at 9.
- Assert rst asynchronously between clk edges at count=4, done=0: all outputs go to 0 before the next edge. After release, mod_q=10 and counting restarts from IDLE.
